// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and default data width.
package fifo_arb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grants the single eligible requester, or the one
// that did not own the previous write when both are eligible.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic [1:0] last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (eligible)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last[0] ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between two producers: round-robin grant, one write
// in flight, ack/err routed back to the owner, and a timeout for a silent FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ACK_TIMEOUT   = 4,
    parameter bit          BLOCK_ON_FULL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_wr_ack,
    input  logic                  fifo_wr_err
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       eligible;
    logic [1:0]       pick;
    logic             blocked;
    logic             finish;

    // A requester whose completion pulse is showing is masked while it drops req.
    assign eligible = {req1 & ~done1 & ~err1, req0 & ~done0 & ~err0};
    assign blocked  = BLOCK_ON_FULL & fifo_full;
    assign finish   = fifo_wr_err | fifo_wr_ack | (cnt == CNT_LAST);

    rr_arb2 u_rr_arb2 (
        .eligible (eligible),
        .last     (last),
        .gnt      (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last       <= 2'b10;
            cnt        <= '0;
            gnt        <= 2'b00;
            busy       <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!blocked && (pick != 2'b00)) begin
                        gnt        <= pick;
                        fifo_din   <= pick[1] ? din1 : din0;
                        fifo_wr_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (finish) begin
                        // wr_err outranks a simultaneous ack; no response at all is a timeout
                        {err1, err0}   <= (fifo_wr_err || !fifo_wr_ack) ? gnt : 2'b00;
                        {done1, done0} <= (!fifo_wr_err && fifo_wr_ack) ? gnt : 2'b00;
                        last           <= gnt;
                        gnt            <= 2'b00;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a blocking and a non-blocking instance driven in
// parallel, compared every cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    localparam int SM_ACK    = 0;
    localparam int SM_ERR    = 1;
    localparam int SM_BOTH   = 2;
    localparam int SM_SILENT = 3;
    localparam int SM_RAND   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [DW-1:0] din [2];
    logic          fifo_full, fifo_wr_ack, fifo_wr_err;

    logic [1:0]    done0_o, done1_o, err0_o, err1_o, busy_o, wr_en_o;
    logic [1:0]    gnt_o  [2];
    logic [DW-1:0] fdin_o [2];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // reference model: owner (-1 = none), age (1 = issue cycle, >=2 = waiting)
    int            owner [2];
    int            age   [2];
    int            lastw [2];
    bit            dq    [2][2];
    bit            eq    [2][2];
    logic [DW-1:0] dinq  [2];
    bit            blockf [2] = '{1'b1, 1'b0};

    int stub_mode = SM_ACK;
    int stub_src  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .ACK_TIMEOUT(TO), .BLOCK_ON_FULL(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req0(req[0]), .req1(req[1]), .din0(din[0]), .din1(din[1]),
        .done0(done0_o[0]), .done1(done1_o[0]), .err0(err0_o[0]), .err1(err1_o[0]),
        .gnt(gnt_o[0]), .busy(busy_o[0]), .fifo_wr_en(wr_en_o[0]), .fifo_din(fdin_o[0]),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .ACK_TIMEOUT(TO), .BLOCK_ON_FULL(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .req0(req[0]), .req1(req[1]), .din0(din[0]), .din1(din[1]),
        .done0(done0_o[1]), .done1(done1_o[1]), .err0(err0_o[1]), .err1(err1_o[1]),
        .gnt(gnt_o[1]), .busy(busy_o[1]), .fifo_wr_en(wr_en_o[1]), .fifo_din(fdin_o[1]),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_en(input int k);
        return (owner[k] >= 0) && (age[k] == 1);
    endfunction

    task automatic model_step(input int k);
        bit nd [2];
        bit ne [2];
        bit e0, e1;
        int p;
        nd = '{1'b0, 1'b0};
        ne = '{1'b0, 1'b0};
        p  = -1;
        if (reset) begin
            owner[k] = -1;
            age[k]   = 0;
            lastw[k] = 1;
            dinq[k]  = '0;
        end else if (owner[k] < 0) begin
            e0 = req[0] && !dq[k][0] && !eq[k][0];
            e1 = req[1] && !dq[k][1] && !eq[k][1];
            if (!(blockf[k] && fifo_full)) begin
                if (e0 && e1)  p = 1 - lastw[k];
                else if (e0)   p = 0;
                else if (e1)   p = 1;
            end
            if (p >= 0) begin
                owner[k] = p;
                age[k]   = 1;
                dinq[k]  = din[p];
            end
        end else if (age[k] == 1) begin
            age[k] = 2;
        end else begin
            // age-1 is the number of waiting cycles including this one
            if (fifo_wr_err || fifo_wr_ack || (age[k] - 1 == int'(TO))) begin
                if (fifo_wr_ack && !fifo_wr_err) nd[owner[k]] = 1'b1;
                else                             ne[owner[k]] = 1'b1;
                lastw[k] = owner[k];
                owner[k] = -1;
            end else begin
                age[k]++;
            end
        end
        dq[k] = nd;
        eq[k] = ne;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt[%0d]", k), 32'(gnt_o[k]),
                (owner[k] < 0) ? 32'd0 : ((owner[k] == 0) ? 32'd1 : 32'd2));
            chk($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(owner[k] >= 0));
            chk($sformatf("wr_en[%0d]", k), 32'(wr_en_o[k]), 32'(exp_en(k)));
            chk($sformatf("fifo_din[%0d]", k), 32'(fdin_o[k]), 32'(dinq[k]));
            chk($sformatf("done0[%0d]", k), 32'(done0_o[k]), 32'(dq[k][0]));
            chk($sformatf("done1[%0d]", k), 32'(done1_o[k]), 32'(dq[k][1]));
            chk($sformatf("err0[%0d]", k), 32'(err0_o[k]), 32'(eq[k][0]));
            chk($sformatf("err1[%0d]", k), 32'(err1_o[k]), 32'(eq[k][1]));
        end
    endtask

    // one clock: model and DUTs advance together, then the FIFO stub responds
    task automatic tick();
        bit en_src;
        en_src = exp_en(stub_src);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
        case (stub_mode)
            SM_ACK:    begin fifo_wr_ack = en_src; fifo_wr_err = 1'b0;   end
            SM_ERR:    begin fifo_wr_ack = 1'b0;   fifo_wr_err = en_src; end
            SM_BOTH:   begin fifo_wr_ack = en_src; fifo_wr_err = en_src; end
            SM_SILENT: begin fifo_wr_ack = 1'b0;   fifo_wr_err = 1'b0;   end
            default: begin
                fifo_wr_ack = en_src ? ($urandom % 4 != 0) : ($urandom % 8 == 0);
                fifo_wr_err = ($urandom % 6 == 0);
            end
        endcase
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 2'b00;
        fifo_full = 1'b0;
        stub_mode = SM_ACK;
        stub_src  = 0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int t, t_en, n, cnt_done, cnt_err;
        logic [1:0] got [4];
        logic [1:0] exp_order [4];

        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        got = '{2'b00, 2'b00, 2'b00, 2'b00};
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; age[k] = 0; lastw[k] = 1; dinq[k] = '0;
            dq[k] = '{1'b0, 1'b0}; eq[k] = '{1'b0, 1'b0};
        end
        din[0] = '0; din[1] = '0;
        fifo_wr_ack = 1'b0; fifo_wr_err = 1'b0;
        do_reset();
        do_reset();

        // single write from requester 0: issue at cycle 1, done at cycle 3
        din[0] = 8'hA5;
        req[0] = 1'b1;
        t = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) begin
                chk("t1_wr_en_c1", 32'(wr_en_o[0]), 32'd1);
                chk("t1_din_c1", 32'(fdin_o[0]), 32'hA5);
            end
            if (done0_o[0] && t < 0) begin
                t = i;
                req[0] = 1'b0;
            end
        end
        chk("t1_done_cycle", 32'(t), 32'd3);

        // both held: grants alternate starting with requester 0
        do_reset();
        din[0] = 8'h11; din[1] = 8'h22;
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            tick();
            if (wr_en_o[0]) begin
                got[n] = gnt_o[0];
                n++;
            end
        end
        chk("t2_grants", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), 32'(got[i]), 32'(exp_order[i]));
        req = 2'b00;
        tick(); tick(); tick(); tick();

        // blocked while full; issue on the cycle after full drops
        do_reset();
        fifo_full = 1'b1;
        din[1] = 8'h3C;
        req[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t3_busy_full", 32'(busy_o[0]), 32'd0);
        chk("t3_en_full", 32'(wr_en_o[0]), 32'd0);
        fifo_full = 1'b0;
        tick();
        chk("t3_issue_after", 32'(wr_en_o[0]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done1_o[0] || err1_o[0]) req[1] = 1'b0;
        end

        // non-blocking instance writes into a full FIFO and gets wr_err; then ack+err together
        do_reset();
        stub_src = 1;
        stub_mode = SM_ERR;
        fifo_full = 1'b1;
        din[0] = 8'h5A;
        req[0] = 1'b1;
        cnt_done = 0; cnt_err = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (err0_o[1])  begin cnt_err++; req[0] = 1'b0; end
            if (done0_o[1]) cnt_done++;
        end
        fifo_full = 1'b0;
        stub_mode = SM_BOTH;
        req[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (err0_o[1])  begin cnt_err++; req[0] = 1'b0; end
            if (done0_o[1]) cnt_done++;
        end
        chk("t4_err0_pulses", 32'(cnt_err), 32'd2);
        chk("t4_done0_pulses", 32'(cnt_done), 32'd0);

        // silent FIFO: four waiting cycles, error pulse the cycle after the last one
        do_reset();
        stub_mode = SM_SILENT;
        din[1] = 8'h77;
        req[1] = 1'b1;
        t = -1; t_en = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wr_en_o[0] && t_en < 0) t_en = i;
            if (err1_o[0] && t < 0) begin
                t = i;
                req[1] = 1'b0;
                fifo_wr_ack = 1'b1;
            end
        end
        chk("t5_timeout_gap", 32'(t - t_en), 32'(TO + 1));
        chk("t5_late_ack_busy", 32'(busy_o[0]), 32'd0);

        // reset in mid-wait: stale ack ignored, req0 served before req1
        do_reset();
        stub_mode = SM_SILENT;
        din[0] = 8'h0F;
        req[0] = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_gnt_after_rst", 32'(gnt_o[0]), 32'd0);
        fifo_wr_ack = 1'b1;
        din[1] = 8'hF0;
        req[1] = 1'b1;
        stub_mode = SM_ACK;
        tick();
        chk("t6_first_gnt", 32'(gnt_o[0]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0_o[0]) req[0] = 1'b0;
            if (done1_o[0]) req[1] = 1'b0;
        end

        // random traffic, random full flag, noisy FIFO responses
        do_reset();
        stub_mode = SM_RAND;
        for (int i = 0; i < 400; i++) begin
            tick();
            fifo_full = ($urandom % 4 == 0);
            for (int r = 0; r < 2; r++) begin
                if (req[r]) begin
                    if ((dq[0][r] || eq[0][r]) && ($urandom % 4 != 0)) req[r] = 1'b0;
                end else if ($urandom % 2 == 0) begin
                    din[r] = DW'($urandom);
                    req[r] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
